core_launch_ctrl: RTL and testbench
===================================

Name: core_launch_ctrl

Overview:
- Run controller that sits directly upstream of the multi-core processor.
- Drives the per-core 2-bit status inputs (00 = off, 01 = run) and watches the processor's end_process[3:0] outputs.
- Signals batch completion and reports cycle count, per-core finish mask and timeout to the system/bench.
- Replaces hard-wired on/off status constants with a start/done handshake.

Parameters:
- NUM_CORES, 4, number of cores controlled; this revision is fixed at 4.
- CYC_W, 32, width of the cycle counter.
- TIMEOUT, 100000, RUN-cycle limit before forced abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  request to launch a batch; sampled only in IDLE.
- core_mask  input  4  cores to enable; latched on an accepted start.
- end_process  input  4  per-core finished flags from the processor; level or pulse.
- status0..status3  output  2 each  per-core run command to the processor: 01 = run, 00 = off.
- busy  output  1  high while a batch runs.
- done  output  1  one-cycle pulse when a batch ends (normal or timeout).
- timeout  output  1  sticky: last batch was aborted.
- finished_mask  output  4  cores seen finished in the current/last batch.
- cycle_count  output  CYC_W  RUN cycles of the current/last batch.

Behaviour:
- All outputs are registered.
- Reset (async assert, sync deassert assumed at system level) sets:
  - state IDLE; status* = 00; busy = 0; done = 0; timeout = 0;
  - finished_mask = 0; cycle_count = 0; active_mask = 0; armed = 0.
- States: IDLE, RUN.
- IDLE:
  - status* = 00.
  - start=1 and core_mask!=0 at edge E0. After E0:
    - active_mask = core_mask;
    - status_i = 01 for masked cores, 00 otherwise;
    - busy = 1; cycle_count = 0; finished_mask = 0; armed = 0; timeout = 0.
    - Next state RUN.
  - start=1 and core_mask==0:
    - No launch; done pulses one cycle after the edge.
    - cycle_count = 0, finished_mask = 0, timeout = 0; stay IDLE.
- RUN, on each edge:
  - cycle_count increments, saturating at all-ones.
  - armed[i] sets when end_process[i]=0 and active_mask[i]=1.
  - finished_mask[i] sets when end_process[i]=1 and armed[i] was already 1. This rejects end flags held over from a previous batch; a core cannot finish in its first RUN cycle.
  - finished_mask bits are sticky, so pulse-style end_process is captured.
  - end_process on unmasked cores is ignored entirely.
  - start is ignored while busy.
- Completion: at the edge where (finished_mask_next & active_mask) == active_mask:
  - status* = 00, busy = 0, done = 1 for exactly one cycle; next state IDLE.
  - cycle_count and finished_mask hold until the next accepted start.
- Timeout: TIMEOUT != 0 and cycle_count reaches TIMEOUT with completion not met at that edge:
  - Same exit as completion, plus timeout = 1.
  - finished_mask shows the partial result.
  - If completion and timeout coincide on the same edge, completion wins and timeout = 0.
- Per-core status drop: a core's status stays 01 until the whole batch ends (no individual drop), matching the processor's expectation of stable status.
- Reset mid-RUN: all outputs return to reset values immediately, asynchronously.
- done and busy are never both high.

Test Plan:
- Reset during RUN: start mask=4'b0011, end_process=0; assert reset_n=0 after 10 cycles -> status0..3=00, busy=0, done=0, cycle_count=0 immediately, without waiting for a clock edge.
- Two-core normal run: start mask=4'b0011; end_process[0] rises on RUN cycle 20, end_process[1] on cycle 35 (levels) -> status0/1=01, status2/3=00 throughout RUN. At the cycle-35 edge: done pulses 1 cycle, busy=0, status all 00, finished_mask=0011, cycle_count=35.
- Stale/unmasked ends: end_process=4'b1111 held from before start, mask=4'b0001; end_process[0] drops at RUN cycle 3 and rises at cycle 8 -> no done before cycle 8. done at cycle 8, finished_mask=0001. Bits 1-3 are ignored.
- Pulse end plus start while busy: mask=4'b1111; one-cycle end pulses at cycles 5, 9, 12, 30; start re-asserted at cycle 10 -> done at cycle 30, cycle_count=30, no relaunch caused by the cycle-10 start.
- Timeout: TIMEOUT=50, mask=4'b0011, only core0 finishes (cycle 10) -> at cycle 50: done=1, timeout=1, finished_mask=0001, status all 00. The next start clears timeout.
- Empty mask: start with core_mask=0 -> done pulse next cycle, busy never rises, status stays 00.

Source files
------------

// File: rtl/core_launch_ctrl.sv
// Batch launch controller: drives per-core run status, waits for every masked core to finish or for a cycle timeout.
// Latency: status/busy one cycle after an accepted start; done one cycle after the completing or timing-out edge.
// Backpressure: start is only accepted in IDLE and is ignored while busy; end_process is sampled every RUN cycle.
module core_launch_ctrl #(
    parameter int NUM_CORES = 4,
    parameter int CYC_W     = 32,
    parameter int TIMEOUT   = 100000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [NUM_CORES-1:0] core_mask,
    input  logic [NUM_CORES-1:0] end_process,
    output logic [1:0]           status0,
    output logic [1:0]           status1,
    output logic [1:0]           status2,
    output logic [1:0]           status3,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout,
    output logic [NUM_CORES-1:0] finished_mask,
    output logic [CYC_W-1:0]     cycle_count
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CYC_W-1:0] CYC_MAX = '1;
    localparam logic [CYC_W-1:0] TMO     = CYC_W'(TIMEOUT);

    state_t                 state_q, state_d;
    logic [NUM_CORES-1:0]   act_q, act_d;
    logic [NUM_CORES-1:0]   arm_q, arm_d;
    logic [NUM_CORES-1:0]   run_q, run_d;
    logic [NUM_CORES-1:0]   fm_d;
    logic [CYC_W-1:0]       cyc_d;
    logic                   busy_d, done_d, to_d;

    logic [CYC_W-1:0]       cyc_inc;
    logic [NUM_CORES-1:0]   fm_nx;
    logic                   all_fin;
    logic                   tmo_hit;

    assign cyc_inc = (cycle_count == CYC_MAX) ? cycle_count : cycle_count + CYC_W'(1);
    // Only a core that has been seen low this batch may report finished, so stale end flags are rejected.
    assign fm_nx   = finished_mask | (end_process & arm_q & act_q);
    assign all_fin = ((fm_nx & act_q) == act_q);
    assign tmo_hit = (TIMEOUT != 0) && (cyc_inc == TMO);

    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        arm_d   = arm_q;
        run_d   = run_q;
        fm_d    = finished_mask;
        cyc_d   = cycle_count;
        busy_d  = busy;
        done_d  = 1'b0;
        to_d    = timeout;
        case (state_q)
            IDLE: begin
                run_d  = '0;
                busy_d = 1'b0;
                if (start) begin
                    cyc_d = '0;
                    fm_d  = '0;
                    to_d  = 1'b0;
                    if (|core_mask) begin
                        act_d   = core_mask;
                        run_d   = core_mask;
                        arm_d   = '0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                cyc_d = cyc_inc;
                fm_d  = fm_nx;
                arm_d = arm_q | (~end_process & act_q);
                // Completion takes priority over a timeout landing on the same edge.
                if (all_fin || tmo_hit) begin
                    run_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    to_d    = ~all_fin;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            act_q         <= '0;
            arm_q         <= '0;
            run_q         <= '0;
            finished_mask <= '0;
            cycle_count   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state_q       <= state_d;
            act_q         <= act_d;
            arm_q         <= arm_d;
            run_q         <= run_d;
            finished_mask <= fm_d;
            cycle_count   <= cyc_d;
            busy          <= busy_d;
            done          <= done_d;
            timeout       <= to_d;
        end
    end

    assign status0 = {1'b0, run_q[0]};
    assign status1 = {1'b0, run_q[1]};
    assign status2 = {1'b0, run_q[2]};
    assign status3 = {1'b0, run_q[3]};

endmodule

// File: tb/tb_core_launch_ctrl.sv
// Bench for core_launch_ctrl: vector table, directed batch scenarios and random traffic against a batch-level model.
module tb_core_launch_ctrl;

    localparam int    TMO  = 50;
    localparam longint MAXC = 64'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  core_mask;
    logic [3:0]  end_process;
    logic [1:0]  status0, status1, status2, status3;
    logic        busy, done, timeout;
    logic [3:0]  finished_mask;
    logic [31:0] cycle_count;

    int n_cmp = 0;
    int n_bad = 0;

    core_launch_ctrl #(.NUM_CORES(4), .CYC_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .core_mask(core_mask),
        .end_process(end_process), .status0(status0), .status1(status1),
        .status2(status2), .status3(status3), .busy(busy), .done(done),
        .timeout(timeout), .finished_mask(finished_mask), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Batch-level reference: which cores are in the batch, which have been seen low, which finished.
    bit     m_busy, m_done, m_to;
    bit     m_act[4], m_seen_low[4], m_fin[4];
    longint m_cyc;

    task automatic model_reset();
        m_busy = 0; m_done = 0; m_to = 0; m_cyc = 0;
        for (int i = 0; i < 4; i++) begin m_act[i] = 0; m_seen_low[i] = 0; m_fin[i] = 0; end
    endtask

    task automatic model_edge();
        int pending;
        m_done = 0;
        if (!m_busy) begin
            if (start) begin
                m_cyc = 0; m_to = 0;
                for (int i = 0; i < 4; i++) m_fin[i] = 0;
                if (core_mask != 0) begin
                    m_busy = 1;
                    for (int i = 0; i < 4; i++) begin m_act[i] = core_mask[i]; m_seen_low[i] = 0; end
                end else begin
                    m_done = 1;
                end
            end
        end else begin
            if (m_cyc < MAXC) m_cyc = m_cyc + 1;
            pending = 0;
            for (int i = 0; i < 4; i++) begin
                if (m_act[i]) begin
                    if (end_process[i] && m_seen_low[i]) m_fin[i] = 1;
                    if (!end_process[i]) m_seen_low[i] = 1;
                    if (!m_fin[i]) pending++;
                end
            end
            if (pending == 0) begin
                m_busy = 0; m_done = 1;
            end else if (m_cyc >= TMO) begin
                m_busy = 0; m_done = 1; m_to = 1;
            end
        end
    endtask

    function automatic logic [63:0] obs();
        return {17'd0, status3, status2, status1, status0, busy, done, timeout, finished_mask, cycle_count};
    endfunction

    function automatic logic [63:0] model_obs();
        logic [7:0] st;
        logic [3:0] fm;
        for (int i = 0; i < 4; i++) begin
            st[2*i +: 2] = (m_busy && m_act[i]) ? 2'b01 : 2'b00;
            fm[i] = m_fin[i];
        end
        return {17'd0, st, m_busy, m_done, m_to, fm, 32'(m_cyc)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model", obs(), model_obs());
        chk("busy_done_excl", 64'(busy & done), 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic        start;
        logic [3:0]  mask;
        logic [3:0]  endp;
        logic [7:0]  st;
        logic        busy;
        logic        done;
        logic        to;
        logic [3:0]  fm;
        logic [31:0] cyc;
    } vec_t;

    vec_t tbl[10];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, got running, expected finished");
        $fatal(1);
    end

    initial begin
        logic [63:0] e;
        tbl[0] = '{1'b1, 4'b0001, 4'b0000, 8'h01, 1'b1, 1'b0, 1'b0, 4'b0000, 32'd0};
        tbl[1] = '{1'b0, 4'b0000, 4'b0000, 8'h01, 1'b1, 1'b0, 1'b0, 4'b0000, 32'd1};
        tbl[2] = '{1'b0, 4'b0000, 4'b0001, 8'h00, 1'b0, 1'b1, 1'b0, 4'b0001, 32'd2};
        tbl[3] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0001, 32'd2};
        tbl[4] = '{1'b1, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b1, 1'b0, 4'b0000, 32'd0};
        tbl[5] = '{1'b0, 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 4'b0000, 32'd0};
        tbl[6] = '{1'b1, 4'b1000, 4'b1000, 8'h40, 1'b1, 1'b0, 1'b0, 4'b0000, 32'd0};
        tbl[7] = '{1'b1, 4'b1111, 4'b1000, 8'h40, 1'b1, 1'b0, 1'b0, 4'b0000, 32'd1};
        tbl[8] = '{1'b0, 4'b0000, 4'b0000, 8'h40, 1'b1, 1'b0, 1'b0, 4'b0000, 32'd2};
        tbl[9] = '{1'b0, 4'b0000, 4'b1000, 8'h00, 1'b0, 1'b1, 1'b0, 4'b1000, 32'd3};

        start = 1'b0; core_mask = '0; end_process = '0; reset_n = 1'b0;
        model_reset();
        #12;
        chk("reset_state", obs(), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Vector table
        for (int r = 0; r < 10; r++) begin
            start = tbl[r].start; core_mask = tbl[r].mask; end_process = tbl[r].endp;
            step();
            e = {17'd0, tbl[r].st, tbl[r].busy, tbl[r].done, tbl[r].to, tbl[r].fm, tbl[r].cyc};
            chk($sformatf("vec_row%0d", r), obs(), e);
        end
        start = 1'b0; end_process = '0;
        step();

        // Reset asserted mid-RUN must clear outputs without a clock edge
        start = 1'b1; core_mask = 4'b0011; end_process = '0;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) step();
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async_reset", {busy, done, status3, status2, status1, status0, cycle_count}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Two-core normal run
        start = 1'b1; core_mask = 4'b0011; end_process = '0;
        step();
        start = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            end_process = {2'b00, (k >= 35) ? 1'b1 : 1'b0, (k >= 20) ? 1'b1 : 1'b0};
            step();
            if (k < 35) chk("two_core_status", {56'd0, status3, status2, status1, status0}, 64'h05);
            if (k == 35) chk("two_core_done", {busy, done, status3, status2, status1, status0, finished_mask, cycle_count},
                             {1'b0, 1'b1, 8'h00, 4'b0011, 32'd35});
            if (k == 36) chk("two_core_hold", {busy, done, finished_mask, cycle_count}, {1'b0, 1'b0, 4'b0011, 32'd35});
        end

        // Stale end flags held across start, unmasked cores ignored
        end_process = 4'b1111; start = 1'b1; core_mask = 4'b0001;
        step();
        start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            end_process = {3'b111, (k >= 3 && k < 8) ? 1'b0 : 1'b1};
            step();
            if (k < 8) chk("stale_no_done", {busy, done}, {1'b1, 1'b0});
            else chk("stale_done", {done, finished_mask, cycle_count}, {1'b1, 4'b0001, 32'd8});
        end

        // Pulse ends, plus a start while busy
        end_process = '0; start = 1'b1; core_mask = 4'b1111;
        step();
        start = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            end_process = (k == 5) ? 4'b0001 : (k == 9) ? 4'b0010 : (k == 12) ? 4'b0100 : (k == 30) ? 4'b1000 : 4'b0000;
            start = (k == 10);
            step();
            if (k == 11) chk("busy_start_ignored", {busy, cycle_count}, {1'b1, 32'd11});
            if (k == 29) chk("pulse_no_early_done", {busy, done, finished_mask}, {1'b1, 1'b0, 4'b0111});
            if (k == 30) chk("pulse_done", {done, busy, finished_mask, cycle_count}, {1'b1, 1'b0, 4'b1111, 32'd30});
        end
        start = 1'b0;

        // Timeout with only core0 finishing
        end_process = '0; start = 1'b1; core_mask = 4'b0011;
        step();
        start = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            end_process = {3'b000, (k >= 10) ? 1'b1 : 1'b0};
            step();
            if (k == 49) chk("timeout_pending", {busy, timeout}, {1'b1, 1'b0});
            if (k == 50) chk("timeout_exit", {done, timeout, busy, status3, status2, status1, status0, finished_mask, cycle_count},
                             {1'b1, 1'b1, 1'b0, 8'h00, 4'b0001, 32'd50});
        end
        end_process = '0;
        step();
        chk("timeout_sticky", 64'(timeout), 64'd1);
        start = 1'b1; core_mask = 4'b0001;
        step();
        chk("timeout_cleared", {timeout, busy}, {1'b0, 1'b1});
        start = 1'b0;
        for (int k = 0; k < 60 && busy; k++) step();

        // Completion and timeout on the same edge: completion wins
        end_process = '0; start = 1'b1; core_mask = 4'b0001;
        step();
        start = 1'b0;
        for (int k = 1; k <= 50; k++) begin
            end_process = (k == 50) ? 4'b0001 : 4'b0000;
            step();
        end
        chk("tie_completion_wins", {done, timeout, finished_mask, cycle_count}, {1'b1, 1'b0, 4'b0001, 32'd50});

        // Empty mask
        start = 1'b1; core_mask = 4'b0000;
        step();
        chk("empty_done", {done, busy, status3, status2, status1, status0}, {1'b1, 1'b0, 8'h00});
        start = 1'b0;
        step();
        chk("empty_after", {done, busy, status3, status2, status1, status0}, {1'b0, 1'b0, 8'h00});

        // Random traffic, with an occasional asynchronous reset
        for (int n = 0; n < 3000; n++) begin
            start       = ($urandom_range(0, 3) == 0);
            core_mask   = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) end_process[i] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) begin
                @(negedge clk);
                do_reset();
            end else begin
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
